uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a uart_tx one frame at a time, popping only after the previous frame is done.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_STATUS_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Overflow
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_ACT  = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   FULL_COUNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem [DEPTH];
  logic              wr_en;
  logic              pop;

  assign o_Full    = (count_q == FULL_COUNT);
  assign o_Empty   = (count_q == '0);
  assign o_Count   = count_q;
  assign o_Tx_DV   = tx_dv_q;
  assign o_Tx_Byte = tx_byte_q;

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    wr_en     = i_Wr_DV && !o_Full;

    case (state_q)
      S_IDLE: begin
        if (!o_Empty) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = mem[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PTR_ONE;
          state_d   = S_WAIT_ACT;
        end
      end
      S_WAIT_ACT: begin
        if (i_Tx_Active) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;

    // Full and empty come from the registered count, so a pop never frees a slot for a same-cycle write.
    case ({wr_en, pop})
      2'b10:   count_d = count_q + COUNT_ONE;
      2'b01:   count_d = count_q - COUNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_en && !i_Reset) mem[wr_ptr_q] <= i_Wr_Byte;
  end

`ifdef UART_TX_FIFO_OVF_STATUS_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q | (i_Wr_DV & o_Full);
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) ovf_q <= 1'b0;
    else         ovf_q <= ovf_d;
  end

  assign o_Overflow = ovf_q;
`else
  assign o_Overflow = 1'b0;
`endif

endmodule
